// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, control-word bit positions and the named control words
// that the sequencer issues.
package sap1_pkg;

   localparam logic [3:0] OpLda = 4'h0;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   // Bit positions in the 12-bit control word, MSB first.
   localparam int unsigned CtrlCp   = 11;
   localparam int unsigned CtrlEp   = 10;
   localparam int unsigned CtrlLmN  = 9;
   localparam int unsigned CtrlCeN  = 8;
   localparam int unsigned CtrlLiN  = 7;
   localparam int unsigned CtrlEiN  = 6;
   localparam int unsigned CtrlLaN  = 5;
   localparam int unsigned CtrlEa   = 4;
   localparam int unsigned CtrlSu   = 3;
   localparam int unsigned CtrlEu   = 2;
   localparam int unsigned CtrlLbN  = 1;
   localparam int unsigned CtrlLoN  = 0;

   localparam logic [11:0] CtrlIdle  = 12'h3E3;
   localparam logic [11:0] CtrlFetT1 = 12'h5E3;
   localparam logic [11:0] CtrlFetT2 = 12'hBE3;
   localparam logic [11:0] CtrlFetT3 = 12'h263;
   localparam logic [11:0] CtrlMarIr = 12'h1A3;
   localparam logic [11:0] CtrlLdaT5 = 12'h2C3;
   localparam logic [11:0] CtrlAluT5 = 12'h2E1;
   localparam logic [11:0] CtrlAddT6 = 12'h3C7;
   localparam logic [11:0] CtrlSubT6 = 12'h3CF;
   localparam logic [11:0] CtrlOutT4 = 12'h3F2;

   function automatic logic op_defined(input logic [3:0] op);
      return op inside {OpLda, OpAdd, OpSub, OpOut, OpHlt};
   endfunction

endpackage

// File: rtl/ring_counter6.sv
// Six-state one-hot T-state ring; hold freezes it, restart returns it to T1.
module ring_counter6 (
   input  logic       clk,
   input  logic       rst,
   input  logic       hold,
   input  logic       restart,
   output logic [5:0] t_state
);

   logic [5:0] state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 6'b000001;
      end else begin
         state_q <= state_d;
      end
   end

   // Hold wins over restart so a halted machine never leaves T4.
   always_comb begin
      state_d = {state_q[4:0], state_q[5]};
      if (restart) state_d = 6'b000001;
      if (hold)    state_d = state_q;
   end

   assign t_state = state_q;

endmodule

// File: rtl/instr_sequencer.sv
// SAP-1 controller-sequencer: instruction register, T-state ring and control-word decode.
// Define SEQ_VAR_CYCLE_EN to cut each instruction short after its last non-idle T-state.
module instr_sequencer
   import sap1_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  bus_in,
   output logic [11:0] ctrl,
   output logic [3:0]  ir_operand,
   output logic [3:0]  opcode,
   output logic [5:0]  t_state,
   output logic        halted
);

   logic [7:0] ir_q, ir_d;
   logic       halted_q, halted_d;
   logic       ring_hold, ring_restart;

   assign opcode     = ir_q[7:4];
   assign ir_operand = ir_q[3:0];
   assign halted     = halted_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q     <= 8'h00;
         halted_q <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      ir_d     = ir_q;
      halted_d = halted_q;
      if (!halted_q && t_state[2]) ir_d = bus_in;
      if (!halted_q && t_state[3] && opcode == OpHlt) halted_d = 1'b1;
   end

   assign ring_hold = halted_q | (t_state[3] & (opcode == OpHlt));

`ifdef SEQ_VAR_CYCLE_EN
   // At T3 the new opcode is still on the bus, so the NOP shortcut decodes bus_in directly.
   assign ring_restart = ~halted_q & ((t_state[2] & ~op_defined(bus_in[7:4])) |
                                      (t_state[3] & (opcode == OpOut)) |
                                      (t_state[4] & (opcode == OpLda)));
`else
   assign ring_restart = 1'b0;
`endif

   ring_counter6 u_ring (
      .clk     (clk),
      .rst     (rst),
      .hold    (ring_hold),
      .restart (ring_restart),
      .t_state (t_state)
   );

   always_comb begin
      ctrl = CtrlIdle;
      if (!rst && !halted_q) begin
         unique case (1'b1)
            t_state[0]: ctrl = CtrlFetT1;
            t_state[1]: ctrl = CtrlFetT2;
            t_state[2]: ctrl = CtrlFetT3;
            t_state[3]: begin
               case (opcode)
                  OpLda, OpAdd, OpSub: ctrl = CtrlMarIr;
                  OpOut:               ctrl = CtrlOutT4;
                  default:             ctrl = CtrlIdle;
               endcase
            end
            t_state[4]: begin
               case (opcode)
                  OpLda:        ctrl = CtrlLdaT5;
                  OpAdd, OpSub: ctrl = CtrlAluT5;
                  default:      ctrl = CtrlIdle;
               endcase
            end
            t_state[5]: begin
               case (opcode)
                  OpAdd:   ctrl = CtrlAddT6;
                  OpSub:   ctrl = CtrlSubT6;
                  default: ctrl = CtrlIdle;
               endcase
            end
            default: ctrl = CtrlIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a step/IR model checked every cycle plus literal checkpoints.
module tb_instr_sequencer;
   import sap1_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  bus_in = 8'h00;
   logic [11:0] ctrl;
   logic [3:0]  ir_operand, opcode;
   logic [5:0]  t_state;
   logic        halted;

   int total = 0;
   int bad   = 0;
   bit run_chk = 1'b1;

   instr_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .bus_in     (bus_in),
      .ctrl       (ctrl),
      .ir_operand (ir_operand),
      .opcode     (opcode),
      .t_state    (t_state),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: T-step number 1..6, instruction byte and halt flag.
   int         m_step = 1;
   logic [7:0] m_ir   = 8'h00;
   bit         m_halt = 1'b0;

   function automatic bit known_op(input logic [3:0] op);
      return (op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hE || op == 4'hF);
   endfunction

   function automatic logic [11:0] want_ctrl(input int s, input logic [3:0] op);
      logic [11:0] w;
      w = 12'h3E3;
      case (s)
         1: w = 12'h5E3;
         2: w = 12'hBE3;
         3: w = 12'h263;
         default: begin
            case (op)
               4'h0: w = (s == 4) ? 12'h1A3 : (s == 5) ? 12'h2C3 : 12'h3E3;
               4'h1: w = (s == 4) ? 12'h1A3 : (s == 5) ? 12'h2E1 : 12'h3C7;
               4'h2: w = (s == 4) ? 12'h1A3 : (s == 5) ? 12'h2E1 : 12'h3CF;
               4'hE: w = (s == 4) ? 12'h3F2 : 12'h3E3;
               default: w = 12'h3E3;
            endcase
         end
      endcase
      return w;
   endfunction

   always @(posedge clk or posedge rst) begin
      int nxt;
      if (rst) begin
         m_step <= 1;
         m_ir   <= 8'h00;
         m_halt <= 1'b0;
      end else if (!m_halt) begin
         nxt = (m_step == 6) ? 1 : m_step + 1;
         if (m_step == 3) m_ir <= bus_in;
         if (m_step == 4 && m_ir[7:4] == 4'hF) begin
            m_halt <= 1'b1;
            nxt = 4;
         end
`ifdef SEQ_VAR_CYCLE_EN
         if (m_step == 3 && !known_op(bus_in[7:4])) nxt = 1;
         if (m_step == 4 && m_ir[7:4] == 4'hE) nxt = 1;
         if (m_step == 5 && m_ir[7:4] == 4'h0) nxt = 1;
`endif
         m_step <= nxt;
      end
   end

   always @(negedge clk) begin
      logic [11:0] w;
      if (run_chk) begin
         w = (rst || m_halt) ? 12'h3E3 : want_ctrl(m_step, m_ir[7:4]);
         check("ctrl", ctrl, w);
         check("t_state", t_state, 6'b1 << (m_step - 1));
         check("opcode", opcode, m_ir[7:4]);
         check("ir_operand", ir_operand, m_ir[3:0]);
         check("halted", halted, m_halt);
      end
   end

   // Single W-bus driver rule.
   always @(negedge clk) begin
      int n;
      if (run_chk) begin
         n = int'(ctrl[CtrlEp]) + int'(!ctrl[CtrlEiN]) + int'(!ctrl[CtrlCeN]) +
             int'(ctrl[CtrlEa]) + int'(ctrl[CtrlEu]);
         total++;
         assert (n <= 1) else begin
            bad++;
            $display("FAIL bus_drivers: got %0d expected <=1 at %0t", n, $time);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic to_t(input logic [5:0] tgt);
      int n;
      n = 0;
      while (t_state !== tgt && n < 12) begin
         cyc();
         n++;
      end
      total++;
      if (t_state !== tgt) begin
         bad++;
         $display("FAIL reach_t: got %0b expected %0b", t_state, tgt);
      end
   endtask

   initial begin
      repeat (2) cyc();
      check("rst_t_state", t_state, 6'b000001);
      check("rst_ctrl", ctrl, 12'h3E3);
      check("rst_ir", {opcode, ir_operand}, 8'h00);
      check("rst_halted", halted, 1'b0);

      // LDA A
      rst = 1'b0;
      bus_in = 8'h0A;
      #1 check("lda_t1", ctrl, 12'h5E3);
      cyc(); check("lda_t2", ctrl, 12'hBE3);
      cyc(); check("lda_t3", ctrl, 12'h263);
      cyc(); check("lda_t4", ctrl, 12'h1A3);
      check("lda_operand", ir_operand, 4'hA);
      cyc(); check("lda_t5", ctrl, 12'h2C3);
`ifndef SEQ_VAR_CYCLE_EN
      cyc(); check("lda_t6", ctrl, 12'h3E3);
`endif

      // SUB 7
      bus_in = 8'h27;
      to_t(6'b000001);
      to_t(6'b100000);
      check("sub_t6", ctrl, 12'h3CF);
      check("sub_opcode", opcode, 4'h2);
      check("sub_operand", ir_operand, 4'h7);

      // ADD 3, aborted by async reset in T5
      bus_in = 8'h13;
      to_t(6'b000001);
      to_t(6'b010000);
      check("add_t5", ctrl, 12'h2E1);
      #3 rst = 1'b1;
      #1;
      check("abort_t_state", t_state, 6'b000001);
      check("abort_ir", {opcode, ir_operand}, 8'h00);
      check("abort_ctrl", ctrl, 12'h3E3);
      cyc();
      rst = 1'b0;
      #1 check("abort_release", ctrl, 12'h5E3);

      // NOP
      bus_in = 8'h50;
`ifdef SEQ_VAR_CYCLE_EN
      to_t(6'b000100);
      cyc(); check("nop_short", t_state, 6'b000001);
`else
      to_t(6'b001000);
      check("nop_t4", ctrl, 12'h3E3);
      to_t(6'b000001);
`endif

      // OUT
      bus_in = 8'hE5;
      to_t(6'b001000);
      check("out_t4", ctrl, 12'h3F2);
`ifdef SEQ_VAR_CYCLE_EN
      cyc(); check("out_short", t_state, 6'b000001);
`else
      to_t(6'b000001);
`endif

      // HLT
      bus_in = 8'hF0;
      to_t(6'b001000);
      check("hlt_t4_ctrl", ctrl, 12'h3E3);
      check("hlt_pre", halted, 1'b0);
      bus_in = 8'h13;
      cyc();
      check("hlt_set", halted, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("hlt_ring", t_state, 6'b001000);
         check("hlt_ctrl", ctrl, 12'h3E3);
      end
      check("hlt_ir_hold", {opcode, ir_operand}, 8'hF0);

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      check("hlt_exit", halted, 1'b0);
      check("hlt_exit_ctrl", ctrl, 12'h5E3);
      bus_in = 8'h0C;
      repeat (8) cyc();

      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
